// File: rtl/credit_pkg.sv
// Shared constants and state encoding for the credits scroller.
package credit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_HOLD   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [11:0] BG_COLOR_DEF = 12'h000;
    localparam int          SCREEN_W     = 640;
    localparam int          SCREEN_H     = 480;

endpackage

// File: rtl/rgb332_to_rgb444.sv
// RGB332 to RGB444 expansion; zero is the transparent key.
module rgb332_to_rgb444 (
    input  logic [7:0]  i_color,
    output logic [11:0] o_rgb,
    output logic        o_opaque
);

    assign o_rgb    = {i_color[7:5], i_color[7],
                       i_color[4:2], i_color[4],
                       i_color[1:0], i_color[1:0]};
    assign o_opaque = (i_color != 8'h00);

endmodule

// File: rtl/credit_scroll_renderer.sv
// Scrolls the credits sprite up to a rest row, holds it, then flags done.
module credit_scroll_renderer
    import credit_pkg::*;
#(
    parameter int          X_POS       = 272,
    parameter int          SPRITE_W    = 96,
    parameter int          SPRITE_H    = 16,
    parameter int          START_Y     = SCREEN_H,
    parameter int          STOP_Y      = 200,
    parameter int          STEP        = 2,
    parameter int          HOLD_FRAMES = 120,
    parameter logic [11:0] BG_COLOR    = BG_COLOR_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic        frame_tick,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic [7:0]  color_data,
    output logic [9:0]  rom_row,
    output logic [9:0]  rom_col,
    output logic [11:0] rgb,
    output logic        sprite_on,
    output logic        busy,
    output logic        done
);

    localparam logic [9:0]  LP_START = 10'(START_Y);
    localparam logic [9:0]  LP_STOP  = 10'(STOP_Y);
    localparam logic [9:0]  LP_STEP  = 10'(STEP);
    localparam logic [9:0]  LP_X_LO  = 10'(X_POS);
    localparam logic [10:0] LP_X_HI  = 11'(X_POS + SPRITE_W);
    localparam logic [10:0] LP_H     = 11'(SPRITE_H);
    localparam logic [6:0]  LP_HOLD  = 7'(HOLD_FRAMES - 1);

    state_t      r_state;
    logic [9:0]  r_sprite_y;
    logic [6:0]  r_hold_cnt;
    logic        r_in_box_d;
    logic        r_video_on_d;
    logic [11:0] r_rgb;
    logic        r_sprite_on;
    logic        r_busy;
    logic        r_done;

    logic signed [10:0] w_next_y;
    logic [10:0]        w_y_end;
    logic               w_in_box;
    logic [11:0]        w_conv;
    logic               w_opaque;

    // Signed difference keeps a large STEP from wrapping past STOP_Y.
    assign w_next_y = $signed({1'b0, r_sprite_y}) - $signed({1'b0, LP_STEP});
    assign w_y_end  = {1'b0, r_sprite_y} + LP_H;

    assign w_in_box = (pixel_x >= LP_X_LO)
                   && ({1'b0, pixel_x} < LP_X_HI)
                   && (pixel_y >= r_sprite_y)
                   && ({1'b0, pixel_y} < w_y_end)
                   && (r_state != ST_IDLE);

    assign rom_row = w_in_box ? (pixel_y - r_sprite_y) : '0;
    assign rom_col = w_in_box ? (pixel_x - LP_X_LO) : '0;

    rgb332_to_rgb444 u_conv (
        .i_color  (color_data),
        .o_rgb    (w_conv),
        .o_opaque (w_opaque)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_sprite_y <= LP_START;
            r_hold_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_busy <= (r_state == ST_SCROLL) || (r_state == ST_HOLD);
            r_done <= (r_state == ST_DONE);
            if (!enable) begin
                r_state    <= ST_IDLE;
                r_sprite_y <= LP_START;
                r_hold_cnt <= '0;
            end else begin
                unique case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            r_state    <= ST_SCROLL;
                            r_sprite_y <= LP_START;
                        end
                    end
                    ST_SCROLL: begin
                        if (frame_tick) begin
                            if (w_next_y <= $signed({1'b0, LP_STOP})) begin
                                r_sprite_y <= LP_STOP;
                                r_hold_cnt <= '0;
                                r_state    <= ST_HOLD;
                            end else begin
                                r_sprite_y <= w_next_y[9:0];
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (frame_tick) begin
                            r_hold_cnt <= r_hold_cnt + 7'd1;
                            if (r_hold_cnt == LP_HOLD)
                                r_state <= ST_DONE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Align box/blank with the ROM's one-cycle read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_box_d   <= 1'b0;
            r_video_on_d <= 1'b0;
            r_rgb        <= BG_COLOR;
            r_sprite_on  <= 1'b0;
        end else begin
            r_in_box_d   <= w_in_box;
            r_video_on_d <= video_on;
            if (r_video_on_d && r_in_box_d && w_opaque) begin
                r_rgb       <= w_conv;
                r_sprite_on <= 1'b1;
            end else begin
                r_rgb       <= BG_COLOR;
                r_sprite_on <= 1'b0;
            end
        end
    end

    assign rgb       = r_rgb;
    assign sprite_on = r_sprite_on;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
